// File: rtl/tabla_patrones.sv
// -----------------------------------------------------------------------------
// tabla_patrones
//   Run-time rewritable pattern -> code lookup table with a registered result.
//   Each qualified input pattern is compared against all DEPTH entries in
//   parallel. The lowest-index valid match wins, and the result appears one
//   cycle later. A saturating counter tracks how many lookups hit.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   wr_en       table write strobe
//   wr_idx      entry index to write (writes at or beyond DEPTH are dropped)
//   wr_pattern  pattern stored in the entry
//   wr_code     code stored in the entry
//   wr_vld      entry enable bit (0 deletes the entry)
//   clr         synchronous clear of hit_count
//   in_valid    data_in qualifier
//   data_in     pattern to look up
//   out_valid   one-cycle pulse marking a fresh lookup result
//   data_out    looked-up code (DEFAULT_CODE on a miss)
//   hit         some valid entry matched
//   hit_idx     index of the matching entry (0 on a miss)
//   hit_count   saturating count of hits
// -----------------------------------------------------------------------------
module tabla_patrones #(
  parameter int              IN_W         = 6,
  parameter int              OUT_W        = 3,
  parameter int              DEPTH        = 8,
  parameter int              PRELOAD      = 1,
  parameter logic [OUT_W-1:0] DEFAULT_CODE = '0,
  localparam int             IW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [IN_W-1:0]  wr_pattern,
  input  logic [OUT_W-1:0] wr_code,
  input  logic             wr_vld,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  data_in,
  output logic             out_valid,
  output logic [OUT_W-1:0] data_out,
  output logic             hit,
  output logic [IW-1:0]    hit_idx,
  output logic [15:0]      hit_count
);

  // The legacy table only makes sense for the original 6-bit -> 3-bit shape.
  localparam bit USE_PRELOAD = (PRELOAD == 1) && (IN_W == 6) && (OUT_W == 3) && (DEPTH >= 5);

  logic [IN_W-1:0]  tab_pat  [DEPTH];
  logic [OUT_W-1:0] tab_code [DEPTH];
  logic             tab_vld  [DEPTH];

  logic             wr_in_range;
  logic             lu_hit;
  logic [IW-1:0]    lu_idx;
  logic [OUT_W-1:0] lu_code;

  function automatic logic [IN_W-1:0] preload_pattern(input int i);
    case (i)
      0:       return IN_W'(6'b101010);
      1:       return IN_W'(6'b101100);
      2:       return IN_W'(6'b101101);
      3:       return IN_W'(6'b011011);
      4:       return IN_W'(6'b101111);
      default: return '0;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] preload_code(input int i);
    case (i)
      0:       return OUT_W'(3'b111);
      1:       return OUT_W'(3'b010);
      2:       return OUT_W'(3'b110);
      3:       return OUT_W'(3'b011);
      4:       return OUT_W'(3'b001);
      default: return '0;
    endcase
  endfunction

  // When DEPTH is not a power of two, wr_idx can name entries that do not
  // exist; those writes are dropped.
  assign wr_in_range = ({1'b0, wr_idx} < (IW+1)'(DEPTH));

  // Table storage. The table is kept in plain registers so that every entry
  // is visible to the parallel compare at the same time. Reset restores the
  // legacy contents when they apply; otherwise it clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_pat[i]  <= USE_PRELOAD ? preload_pattern(i) : '0;
        tab_code[i] <= USE_PRELOAD ? preload_code(i) : '0;
        tab_vld[i]  <= USE_PRELOAD && (i < 5);
      end
    end else if (wr_en && wr_in_range) begin
      tab_pat[wr_idx]  <= wr_pattern;
      tab_code[wr_idx] <= wr_code;
      tab_vld[wr_idx]  <= wr_vld;
    end
  end

  // Parallel compare and priority encode. The loop walks downward so that
  // the last assignment, which is the one that sticks, comes from the lowest
  // matching index. The compare reads the current table contents, so a write
  // in the same cycle does not affect this lookup.
  always_comb begin
    lu_hit  = 1'b0;
    lu_idx  = '0;
    lu_code = DEFAULT_CODE;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tab_vld[i] && (tab_pat[i] == data_in)) begin
        lu_hit  = 1'b1;
        lu_idx  = IW'(i);
        lu_code = tab_code[i];
      end
    end
  end

  // Result register. out_valid is a one-cycle pulse. The result fields only
  // load on a qualified lookup and otherwise hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= DEFAULT_CODE;
      hit       <= 1'b0;
      hit_idx   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= lu_code;
        hit      <= lu_hit;
        hit_idx  <= lu_idx;
      end
    end
  end

  // Hit counter. It advances on the same edge that registers a hit, so it
  // already includes the hit being shown on the outputs. It sticks at
  // all-ones rather than wrapping. clr wins over a simultaneous hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (clr) begin
      hit_count <= '0;
    end else if (in_valid && lu_hit && (hit_count != 16'hFFFF)) begin
      hit_count <= hit_count + 16'd1;
    end
  end

endmodule
